// File: rtl/sd_cmd_tx_if.sv
// sd_cmd_tx_if: command request handshake (valid/ready with index and argument).
interface sd_cmd_tx_if;
  logic        valid;
  logic        ready;
  logic [5:0]  idx;
  logic [31:0] arg;

  modport master (
    output valid,
    output idx,
    output arg,
    input  ready
  );

  modport slave (
    input  valid,
    input  idx,
    input  arg,
    output ready
  );
endinterface

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: SD CMD-line transmitter, 48-bit frame with CRC7 and an idle gap.
// Optional CRC wait timeout enabled by defining SD_CMD_TX_TIMEOUT_EN.
module sd_cmd_tx #(
  parameter int GAP_BITS    = 8,
  parameter int CRC_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sd_ce_i,
  sd_cmd_tx_if.slave  req,
  output logic        crc_en_o,
  output logic [39:0] crc_data_o,
  input  logic [6:0]  crc_i,
  input  logic        crc_valid_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  if (GAP_BITS < 1 || GAP_BITS > 255 ||
      CRC_TIMEOUT < 2 || CRC_TIMEOUT > 1023) begin : g_bad_param
    $error("sd_cmd_tx: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC_REQ,
    S_CRC_WAIT,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e      state_q;
  logic [39:0] data_q;
  logic [47:0] sh_q;
  logic [5:0]  bit_q;
  logic [7:0]  gap_q;
  logic        cmd_q;
  logic        oe_q;
  logic        crc_en_q;
  logic        done_q;

`ifdef SD_CMD_TX_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(CRC_TIMEOUT - 1);
  logic [9:0] tmo_q;
  logic       err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign req.ready  = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign crc_en_o   = crc_en_q;
  assign crc_data_o = data_q;
  assign cmd_o      = cmd_q;
  assign cmd_oe_o   = oe_q;
  assign done_o     = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      sh_q     <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      cmd_q    <= 1'b1;
      oe_q     <= 1'b0;
      crc_en_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SD_CMD_TX_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      crc_en_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SD_CMD_TX_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (req.valid) begin
            data_q   <= {2'b01, req.idx, req.arg};
            crc_en_q <= 1'b1;
            state_q  <= S_CRC_REQ;
          end
        end
        S_CRC_REQ: begin
`ifdef SD_CMD_TX_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= S_CRC_WAIT;
        end
        S_CRC_WAIT: begin
          if (crc_valid_i) begin
            sh_q    <= {data_q, crc_i, 1'b1};
            bit_q   <= 6'd48;
            state_q <= S_SHIFT;
          end
`ifdef SD_CMD_TX_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 10'd1;
          end
`endif
        end
        S_SHIFT: begin
          if (sd_ce_i) begin
            // bit_q==0 means the end bit has had its full period
            if (bit_q != 6'd0) begin
              cmd_q <= sh_q[47];
              oe_q  <= 1'b1;
              sh_q  <= {sh_q[46:0], 1'b1};
              bit_q <= bit_q - 6'd1;
            end else begin
              cmd_q   <= 1'b1;
              oe_q    <= 1'b0;
              gap_q   <= 8'(GAP_BITS);
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (sd_ce_i) begin
            if (gap_q <= 8'd1) begin
              gap_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              gap_q <= gap_q - 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: directed table-driven bench for sd_cmd_tx with a behavioural crc7.
// sd_ce strobes every 4 clocks; frames captured from cmd_o while cmd_oe_o is high.
module tb_sd_cmd_tx;

  localparam int GAP = 8;
  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        sd_ce;
  logic        crc_en;
  logic [39:0] crc_data;
  logic [6:0]  crc_val;
  logic        crc_valid;
  logic        cmd;
  logic        cmd_oe;
  logic        busy;
  logic        done;
  logic        err;
  logic        stub_valid;
  logic        poke_valid;
  logic        stub_on;
  int          lat;

  int total;
  int bad;

  assign crc_valid = stub_valid | poke_valid;

  sd_cmd_tx_if rq ();

  sd_cmd_tx #(
    .GAP_BITS    (GAP),
    .CRC_TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sd_ce_i     (sd_ce),
    .req         (rq),
    .crc_en_o    (crc_en),
    .crc_data_o  (crc_data),
    .crc_i       (crc_val),
    .crc_valid_i (crc_valid),
    .cmd_o       (cmd),
    .cmd_oe_o    (cmd_oe),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // strobe generator and serial capture
  int          ce_total;
  int          oe_total;
  int          last_bit_ce;
  logic [47:0] cap;
  logic        ce_prev;
  int          div;

  initial begin
    sd_ce       = 1'b0;
    ce_prev     = 1'b0;
    div         = 0;
    ce_total    = 0;
    oe_total    = 0;
    last_bit_ce = 0;
    cap         = '0;
    forever begin
      @(negedge clk);
      if (ce_prev) begin
        ce_total++;
        if (cmd_oe) begin
          cap         = {cap[46:0], cmd};
          oe_total++;
          last_bit_ce = ce_total;
        end
      end
      div     = (div == 3) ? 0 : div + 1;
      sd_ce   = (div == 3);
      ce_prev = sd_ce;
    end
  end

  // behavioural crc7: result valid lat cycles after the start pulse
  initial begin
    stub_valid = 1'b0;
    crc_val    = '0;
    forever begin
      @(negedge clk);
      if (crc_en && stub_on) begin
        repeat (lat) @(negedge clk);
        crc_val    = crc7(crc_data);
        stub_valid = 1'b1;
        @(negedge clk);
        stub_valid = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [5:0] i, input logic [31:0] a,
                      input logic [39:0] exp_data);
    int n;
    rq.valid = 1'b1;
    rq.idx   = i;
    rq.arg   = a;
    n = 0;
    while (!rq.ready && n < 4000) begin
      tick();
      n++;
    end
    tick();
    rq.valid = 1'b0;
    chk("accept_wait", 64'(n < 4000), 64'd1);
    chk("crc_en", 64'(crc_en), 64'd1);
    chk("crc_data", 64'(crc_data), 64'(exp_data));
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    chk("done_wait", 64'(done), 64'd1);
  endtask

  task automatic check_frame(input logic [47:0] frame,
                             input logic [39:0] data, input int oe0);
    chk("frame", 64'(cap), 64'(frame));
    chk("oe_strobes", 64'(oe_total - oe0), 64'd48);
    chk("gap_strobes", 64'(ce_total - last_bit_ce), 64'(GAP + 1));
    chk("ready_at_done", 64'(rq.ready), 64'd1);
    chk("err_low", 64'(err), 64'd0);
    chk("data_stable", 64'(crc_data), 64'(data));
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          lat;
    logic [39:0] data;
    logic [47:0] frame;
  } vec_t;

  initial begin
    vec_t v[4];
    int   oe0;
    int   n;
    int   dn;

    v[0] = '{6'd0,  32'h0000_0000, 40, 40'h40_0000_0000, 48'h4000_0000_0095};
    v[1] = '{6'd8,  32'h0000_01AA, 1,  40'h48_0000_01AA, 48'h4800_0001_AA87};
    v[2] = '{6'd17, 32'h0000_0000, 7,  40'h51_0000_0000, 48'h5100_0000_0055};
    v[3] = '{6'd55, 32'h0000_0000, 40, 40'h77_0000_0000, 48'h7700_0000_0065};

    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    rq.valid   = 1'b0;
    rq.idx     = '0;
    rq.arg     = '0;
    poke_valid = 1'b0;
    stub_on    = 1'b1;
    lat        = 40;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_cmd", 64'(cmd), 64'd1);
    chk("rst_oe", 64'(cmd_oe), 64'd0);
    chk("rst_crc_en", 64'(crc_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(rq.ready), 64'd1);
    chk("rst_data", 64'(crc_data), 64'd0);

    // crc_valid while idle must be ignored
    poke_valid = 1'b1;
    tick();
    poke_valid = 1'b0;
    tick();
    chk("idle_poke_busy", 64'(busy), 64'd0);
    chk("idle_poke_cmd", 64'(cmd), 64'd1);
    chk("idle_poke_oe", 64'(cmd_oe), 64'd0);

    for (int i = 0; i < 4; i++) begin
      lat = v[i].lat;
      oe0 = oe_total;
      send(v[i].idx, v[i].arg, v[i].data);
      wait_done();
      check_frame(v[i].frame, v[i].data, oe0);
      tick();
      chk("done_pulse", 64'(done), 64'd0);
    end

    // back-to-back: CMD55 held valid while CMD17 is in flight
    lat = 40;
    oe0 = oe_total;
    send(6'd17, 32'h0, v[2].data);
    rq.valid = 1'b1;
    rq.idx   = 6'd55;
    rq.arg   = 32'h0;
    wait_done();
    check_frame(v[2].frame, v[2].data, oe0);
    chk("b2b_valid_held", 64'(rq.valid), 64'd1);
    oe0 = oe_total;
    tick();
    rq.valid = 1'b0;
    chk("b2b_crc_en", 64'(crc_en), 64'd1);
    chk("b2b_data", 64'(crc_data), 64'(v[3].data));
    chk("b2b_done_pulse", 64'(done), 64'd0);
    wait_done();
    check_frame(v[3].frame, v[3].data, oe0);
    tick();

    // reset at bit 20 of SHIFT, with a request presented during reset
    oe0 = oe_total;
    send(6'd0, 32'h0, v[0].data);
    n = 0;
    while (oe_total - oe0 < 20 && n < 3000) begin
      tick();
      n++;
    end
    chk("bit20_reached", 64'(oe_total - oe0), 64'd20);
    rst      = 1'b1;
    rq.valid = 1'b1;
    rq.idx   = 6'd8;
    rq.arg   = 32'h1AA;
    tick();
    rst      = 1'b0;
    rq.valid = 1'b0;
    chk("midrst_cmd", 64'(cmd), 64'd1);
    chk("midrst_oe", 64'(cmd_oe), 64'd0);
    chk("midrst_ready", 64'(rq.ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_data", 64'(crc_data), 64'd0);
    tick();
    chk("midrst_no_accept", 64'(crc_en), 64'd0);
    dn = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done || cmd_oe) dn++;
    end
    chk("midrst_quiet", 64'(dn), 64'd0);

    lat = 40;
    oe0 = oe_total;
    send(v[0].idx, v[0].arg, v[0].data);
    wait_done();
    check_frame(v[0].frame, v[0].data, oe0);
    tick();

`ifdef SD_CMD_TX_TIMEOUT_EN
    stub_on = 1'b0;
    send(6'd0, 32'h0, v[0].data);
    n  = 0;
    dn = 0;
    while (!err && n < 200) begin
      tick();
      n++;
      if (cmd_oe) dn++;
    end
    chk("tmo_latency", 64'(n), 64'd17);
    chk("tmo_no_oe", 64'(dn), 64'd0);
    chk("tmo_idle", 64'(busy), 64'd0);
    tick();
    chk("tmo_err_pulse", 64'(err), 64'd0);
    stub_on = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
